// File: rtl/mem_access_unit.sv
// M-stage memory access unit: issues one load/store request at a time on the
// data bus, stalls the pipeline until the response arrives, and returns the raw word.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        excM,
  input  logic        flushM,
  input  logic        stall_other,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic [31:0] rdataM
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  // The illegal size code 3 behaves as a full word everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    logic [1:0] r;
    r = (sz == 2'd3) ? 2'd2 : sz;
    return r;
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {4{wd[7:0]}};
      2'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access;
  logic        req_raw;
  logic        stall_raw;

  assign access = memenM & ~excM & ~flushM;

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    req_raw    = 1'b0;
    stall_raw  = 1'b0;
    data_wr    = wr_q;
    data_size  = size_q;
    data_addr  = addr_q;
    data_wdata = wdata_q;
    rdataM     = rdata_q;

    case (state_q)
      IDLE: begin
        data_wr    = memwriteM;
        data_size  = norm_size(sizeM);
        data_addr  = addrM;
        data_wdata = rep_wdata(sizeM, wdataM);
        if (access) begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          wr_d      = memwriteM;
          size_d    = norm_size(sizeM);
          addr_d    = addrM;
          wdata_d   = rep_wdata(sizeM, wdataM);
          state_d   = data_addr_ok ? DATA : ADDR;
        end
      end

      // Request must stay asserted with frozen fields until the address is accepted.
      ADDR: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        if (flushM) cancel_d = 1'b1;
        if (data_addr_ok) state_d = DATA;
      end

      DATA: begin
        stall_raw = 1'b1;
        if (data_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q) begin
            state_d = IDLE;
          end else begin
            stall_raw = 1'b0;
            rdataM    = data_rdata;
            rdata_d   = data_rdata;
            state_d   = stall_other ? DONE : IDLE;
          end
        end else if (flushM) begin
          cancel_d = 1'b1;
        end
      end

      // Response already consumed; just wait for the rest of the pipeline to move.
      DONE: begin
        if (!stall_other) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (cancel_q && memenM) stall_raw = 1'b1;
  end

  assign data_req  = rst & req_raw;
  assign mem_stall = rst & stall_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed handshake scenarios followed by randomized
// transactions checked against a transaction-timing reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, excM, flushM, stall_other;
  logic [1:0]  sizeM;
  logic [31:0] addrM, wdataM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic [31:0] rdataM;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd = 32'd0;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .memenM(memenM), .memwriteM(memwriteM), .sizeM(sizeM),
    .addrM(addrM), .wdataM(wdataM),
    .excM(excM), .flushM(flushM), .stall_other(stall_other),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_stall(mem_stall), .rdataM(rdataM)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    memenM = 1'b0; memwriteM = 1'b0; sizeM = 2'd2; addrM = 32'd0; wdataM = 32'd0;
    excM = 1'b0; flushM = 1'b0; stall_other = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    memenM = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #2;
      n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL reset_held req/stall c%0d: got %b want 00", c, {data_req, mem_stall}); end
    end
    n_tests++; if (rdataM !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdataM); end
    @(negedge clk); rst = 1'b1; idle_inputs(); #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL reset_release req/stall: got %b want 00", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== 32'd0) begin n_fail++; $display("FAIL reset_release rdata: got %h want 00000000", rdataM); end
  endtask

  task automatic test_word_load();
    @(negedge clk); idle_inputs();
    memenM = 1'b1; sizeM = 2'd2; addrM = 32'h0000_1000; data_addr_ok = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b11) begin n_fail++; $display("FAIL wload_c0 req/stall: got %b want 11", {data_req, mem_stall}); end
    n_tests++; if ({data_wr, data_size, data_addr} !== {1'b0, 2'd2, 32'h0000_1000}) begin n_fail++; $display("FAIL wload_c0 fields: got %b %0d %h want 0 2 00001000", data_wr, data_size, data_addr); end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL wload_c1 req/stall: got %b want 00", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wload_c1 rdata: got %h want deadbeef", rdataM); end
    @(negedge clk); idle_inputs(); data_rdata = 32'h0BAD_F00D; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL wload_c2 req/stall: got %b want 00", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wload_c2 rdata hold: got %h want deadbeef", rdataM); end
    last_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte_store();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); idle_inputs();
      memenM = 1'b1; memwriteM = 1'b1; sizeM = 2'd0; addrM = 32'h0000_0003; wdataM = 32'h0000_00A5;
      data_addr_ok = (c == 3); #2;
      n_tests++; if ({data_req, mem_stall} !== 2'b11) begin n_fail++; $display("FAIL bstore_c%0d req/stall: got %b want 11", c, {data_req, mem_stall}); end
      n_tests++; if ({data_wr, data_size, data_addr, data_wdata} !== {1'b1, 2'd0, 32'h0000_0003, 32'hA5A5_A5A5})
        begin n_fail++; $display("FAIL bstore_c%0d fields: got %b %0d %h %h want 1 0 00000003 a5a5a5a5", c, data_wr, data_size, data_addr, data_wdata); end
    end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_5A5A; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL bstore_resp req/stall: got %b want 00", {data_req, mem_stall}); end
    @(negedge clk); idle_inputs(); #2;
    n_tests++; if (rdataM !== 32'h0000_5A5A) begin n_fail++; $display("FAIL bstore_rdata: got %h want 00005a5a", rdataM); end
    last_rd = 32'h0000_5A5A;
  endtask

  task automatic test_done_stall();
    @(negedge clk); idle_inputs();
    memenM = 1'b1; sizeM = 2'd1; addrM = 32'h0000_2002; data_addr_ok = 1'b1; #2;
    n_tests++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL done_c0 req: got %b want 1", data_req); end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; stall_other = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL done_c1 req/stall: got %b want 00", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL done_c1 rdata: got %h want cafef00d", rdataM); end
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h9999_9999; data_addr_ok = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL done_c2 req/stall: got %b want 00", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL done_c2 rdata hold: got %h want cafef00d", rdataM); end
    @(negedge clk); data_data_ok = 1'b0; data_addr_ok = 1'b0; stall_other = 1'b0; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL done_c3 req/stall: got %b want 00", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL done_c3 rdata hold: got %h want cafef00d", rdataM); end
    last_rd = 32'hCAFE_F00D;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle_inputs();
    memenM = 1'b1; sizeM = 2'd2; addrM = 32'h0000_3000; data_addr_ok = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall, data_addr} !== {2'b11, 32'h0000_3000}) begin n_fail++; $display("FAIL b2b_c0 req/stall/addr: got %b%b %h want 11 00003000", data_req, mem_stall, data_addr); end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h3131_3131; #2;
    n_tests++; if ({mem_stall, rdataM} !== {1'b0, 32'h3131_3131}) begin n_fail++; $display("FAIL b2b_c1 stall/rdata: got %b %h want 0 31313131", mem_stall, rdataM); end
    @(negedge clk); data_data_ok = 1'b0; addrM = 32'h0000_3004; data_addr_ok = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall, data_addr} !== {2'b11, 32'h0000_3004}) begin n_fail++; $display("FAIL b2b_c2 req/stall/addr: got %b%b %h want 11 00003004", data_req, mem_stall, data_addr); end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h3232_3232; #2;
    n_tests++; if ({mem_stall, rdataM} !== {1'b0, 32'h3232_3232}) begin n_fail++; $display("FAIL b2b_c3 stall/rdata: got %b %h want 0 32323232", mem_stall, rdataM); end
    last_rd = 32'h3232_3232;
  endtask

  task automatic test_flush_cancel();
    @(negedge clk); idle_inputs();
    memenM = 1'b1; addrM = 32'h0000_4000; data_addr_ok = 1'b1; #2;
    n_tests++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL flush_c0 req: got %b want 1", data_req); end
    @(negedge clk); data_addr_ok = 1'b0; flushM = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b01) begin n_fail++; $display("FAIL flush_c1 req/stall: got %b want 01", {data_req, mem_stall}); end
    @(negedge clk); flushM = 1'b0; addrM = 32'h0000_5000; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b01) begin n_fail++; $display("FAIL flush_c2 req/stall: got %b want 01", {data_req, mem_stall}); end
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h1111_1111; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b01) begin n_fail++; $display("FAIL flush_c3 req/stall: got %b want 01", {data_req, mem_stall}); end
    n_tests++; if (rdataM !== last_rd) begin n_fail++; $display("FAIL flush_c3 discarded rdata: got %h want %h", rdataM, last_rd); end
    @(negedge clk); data_data_ok = 1'b0; data_addr_ok = 1'b1; #2;
    n_tests++; if ({data_req, mem_stall, data_addr} !== {2'b11, 32'h0000_5000}) begin n_fail++; $display("FAIL flush_c4 new req: got %b%b %h want 11 00005000", data_req, mem_stall, data_addr); end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2222_2222; #2;
    n_tests++; if ({mem_stall, rdataM} !== {1'b0, 32'h2222_2222}) begin n_fail++; $display("FAIL flush_c5 stall/rdata: got %b %h want 0 22222222", mem_stall, rdataM); end
    last_rd = 32'h2222_2222;
  endtask

  task automatic test_exception();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs();
      memenM = 1'b1; excM = 1'b1; addrM = 32'h0000_0001; data_addr_ok = 1'b1; #2;
      n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL exc_c%0d req/stall: got %b want 00", c, {data_req, mem_stall}); end
    end
    @(negedge clk); idle_inputs(); #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL exc_after req/stall: got %b want 00", {data_req, mem_stall}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_inputs(); memenM = 1'b1; addrM = 32'h0000_6000; #2;
    @(negedge clk); #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b11) begin n_fail++; $display("FAIL rstmid_addr req/stall: got %b want 11", {data_req, mem_stall}); end
    @(negedge clk); rst = 1'b0; #2;
    n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL rstmid_low req/stall: got %b want 00", {data_req, mem_stall}); end
    @(negedge clk); rst = 1'b1; idle_inputs(); #2;
    n_tests++; if ({data_req, mem_stall, rdataM} !== {2'b00, 32'd0}) begin n_fail++; $display("FAIL rstmid_after: got %b%b %h want 00 00000000", data_req, mem_stall, rdataM); end
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h7777_7777; #2;
    n_tests++; if ({data_req, mem_stall, rdataM} !== {2'b00, 32'd0}) begin n_fail++; $display("FAIL rstmid_stray: got %b%b %h want 00 00000000", data_req, mem_stall, rdataM); end
    @(negedge clk); idle_inputs(); #2;
    n_tests++; if (rdataM !== 32'd0) begin n_fail++; $display("FAIL rstmid_hold rdata: got %h want 00000000", rdataM); end
    last_rd = 32'd0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 150; t++) begin
      int d1, d2, s, ca, cd, g, kind;
      logic wr, exp_req, exp_stall;
      logic [1:0] sz, es;
      logic [31:0] ad, wd, rd, ew, exp_rd;
      d1 = int'($urandom_range(0, 3)); d2 = int'($urandom_range(1, 3)); s = int'($urandom_range(0, 2));
      wr = 1'($urandom); sz = 2'($urandom); ad = $urandom; wd = $urandom; rd = $urandom;
      es = (sz == 2'd3) ? 2'd2 : sz;
      case (sz)
        2'd0:    ew = 32'(wd[7:0]) * 32'h0101_0101;
        2'd1:    ew = 32'(wd[15:0]) * 32'h0001_0001;
        default: ew = wd;
      endcase
      ca = d1;
      cd = d1 + d2;
      for (int c = 0; c <= cd + s; c++) begin
        @(negedge clk);
        memenM = 1'b1; excM = 1'b0; flushM = 1'b0;
        if (c >= 1 && c <= ca) begin
          memwriteM = 1'($urandom); sizeM = 2'($urandom); addrM = $urandom; wdataM = $urandom;
        end else begin
          memwriteM = wr; sizeM = sz; addrM = ad; wdataM = wd;
        end
        data_addr_ok = (c == ca) ? 1'b1 : (c > ca) ? 1'($urandom) : 1'b0;
        data_data_ok = (c == cd) ? 1'b1 : (c <= ca || c > cd) ? 1'($urandom) : 1'b0;
        data_rdata   = (c == cd) ? rd : $urandom;
        stall_other  = (c < cd) ? 1'($urandom) : (c < cd + s);
        #2;
        exp_req   = (c <= ca);
        exp_stall = (c < cd);
        exp_rd    = (c >= cd) ? rd : last_rd;
        n_tests++; if ({data_req, mem_stall} !== {exp_req, exp_stall}) begin n_fail++; $display("FAIL rand t%0d c%0d req/stall: got %b%b want %b%b", t, c, data_req, mem_stall, exp_req, exp_stall); end
        n_tests++; if (rdataM !== exp_rd) begin n_fail++; $display("FAIL rand t%0d c%0d rdata: got %h want %h", t, c, rdataM, exp_rd); end
        if (exp_req) begin
          n_tests++; if ({data_wr, data_size, data_addr, data_wdata} !== {wr, es, ad, ew})
            begin n_fail++; $display("FAIL rand t%0d c%0d fields: got %b %0d %h %h want %b %0d %h %h", t, c, data_wr, data_size, data_addr, data_wdata, wr, es, ad, ew); end
        end
      end
      last_rd = rd;
      g = int'($urandom_range(0, 2));
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        kind = int'($urandom_range(0, 2));
        memenM = (kind != 0); excM = (kind == 1); flushM = (kind == 2);
        addrM = $urandom; data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom);
        data_rdata = $urandom; stall_other = 1'($urandom);
        #2;
        n_tests++; if ({data_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL rand_gap t%0d kind%0d req/stall: got %b want 00", t, kind, {data_req, mem_stall}); end
        n_tests++; if (rdataM !== last_rd) begin n_fail++; $display("FAIL rand_gap t%0d rdata: got %h want %h", t, rdataM, last_rd); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_word_load();
    test_byte_store();
    test_done_stall();
    test_back_to_back();
    test_flush_cancel();
    test_exception();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
REQ-003 SHALL have ports memenM, memwriteM  input  1 each  M-stage access enable and write flag from the pipeline control registers.
REQ-004 SHALL have port sizeM  input  2  access size: 0 byte, 1 half, 2 word; 3 is illegal and treated as word.
REQ-005 SHALL have ports addrM, wdataM  input  32 each  M-stage effective address and store data.
REQ-006 SHALL have ports excM, flushM, stall_other  input  1 each  address exception on the M instruction, M-stage flush, stall raised by any other source.
REQ-007 SHALL have ports data_req, data_wr  output  1 each, data_size  output  2, data_addr, data_wdata  output  32 each  memory request channel.
REQ-008 SHALL have ports data_addr_ok, data_data_ok  input  1 each, data_rdata  input  32  memory handshake and response.
REQ-009 SHALL have ports mem_stall  output  1, rdataM  output  32  pipeline stall request and raw load word.

Function
REQ-010 SHALL define access = memenM & ~excM & ~flushM.
REQ-011 SHALL implement states IDLE, ADDR, DATA, DONE plus a 1-bit cancel flag.
REQ-012 SHALL drive data_req=1 in IDLE when access, and in ADDR unconditionally; otherwise 0.
REQ-013 SHALL drive data_wr, data_size, data_addr, data_wdata from the M-stage inputs in IDLE and from registered copies in ADDR, so they stay stable while data_req=1.
REQ-014 SHALL replicate store data: byte {4{wdataM[7:0]}}, half {2{wdataM[15:0]}}, word wdataM; data_addr=addrM unmodified.
REQ-015 IDLE: access & data_addr_ok -> DATA; access & ~data_addr_ok -> ADDR; else stay.
REQ-016 ADDR: data_addr_ok -> DATA; else stay; data_req SHALL never deassert before data_addr_ok.
REQ-017 DATA: data_data_ok & cancel -> IDLE, clear cancel, discard data; data_data_ok & ~cancel & stall_other -> DONE; data_data_ok & ~cancel & ~stall_other -> IDLE; else stay.
REQ-018 SHALL capture data_rdata into rdataM on the data_data_ok cycle when ~cancel (reads and writes alike); rdataM SHALL equal data_rdata combinationally in that same cycle.
REQ-019 DONE: ~stall_other -> IDLE; no new request in DONE; rdataM holds the captured word.
REQ-020 mem_stall SHALL be 1 in IDLE when access; in ADDR; in DATA unless (data_data_ok & ~cancel); 0 in DONE.
REQ-021 flushM=1 while in ADDR or DATA SHALL set cancel; the in-flight handshake completes and the response is discarded.
REQ-022 While cancel=1, mem_stall SHALL be 1 whenever memenM=1, and no new request SHALL issue until the cancelled response returns.
REQ-023 data_data_ok in IDLE, ADDR or DONE SHALL be ignored.
REQ-024 At most one transaction SHALL be outstanding at any time.
REQ-025 excM=1 SHALL suppress the request entirely; mem_stall stays 0 for that instruction.

Reset
REQ-026 On rst==0: state=IDLE, cancel=0, rdataM=0, all registered request fields=0.
REQ-027 While rst==0, data_req=0 and mem_stall=0 regardless of other inputs.
REQ-028 Reset mid-transaction SHALL abandon it; a subsequent stray data_data_ok SHALL be ignored per REQ-023.

Verification
REQ-029 Word load addr 0x00001000, addr_ok same cycle, data_ok next cycle with 0xDEADBEEF -> data_req 1 cycle, mem_stall 1 cycle, rdataM=0xDEADBEEF, back to IDLE.
REQ-030 Byte store addr 0x00000003 wdata 0x000000A5, addr_ok delayed 3 cycles -> data_req held 4 cycles with data_size=0, data_wdata=0xA5A5A5A5 and data_addr stable; mem_stall high until data_ok.
REQ-031 Load completes while stall_other=1 for 2 cycles -> DONE, mem_stall 0, rdataM held, no second data_req, then IDLE.
REQ-032 flushM pulse in DATA, new load presented next cycle -> mem_stall 1, no data_req until the first data_ok (data discarded), then new request issues.
REQ-033 excM=1 with memenM=1 -> data_req 0, mem_stall 0.
REQ-034 rst low in ADDR for 1 cycle -> IDLE, data_req 0, rdataM 0; later data_data_ok pulse ignored.
